// File: rtl/n64_scb_service_arbiter.sv
// Round-robin arbiter that hands CHANNELS service requests to one controller port,
// carrying request/response payloads and aborting stalled transactions on timeout.
module n64_scb_service_arbiter #(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 42,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ID_WIDTH       = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            channel_enable,
  input  logic [CHANNELS-1:0]            req_pending,
  input  logic [CHANNELS*DATA_WIDTH-1:0] req_data,
  output logic [CHANNELS-1:0]            req_done,
  output logic                           req_error,
  output logic                           req_wdata_valid,
  output logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           ctrl_pending,
  output logic                           ctrl_irq,
  output logic [ID_WIDTH-1:0]            ctrl_id,
  output logic [DATA_WIDTH-1:0]          ctrl_data,
  input  logic                           ctrl_ack,
  input  logic                           ctrl_done,
  input  logic                           ctrl_wdata_valid,
  input  logic [DATA_WIDTH-1:0]          ctrl_wdata
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFERED,
    S_SERVICING,
    S_COMPLETE
  } state_t;

  state_t                  r_state;
  logic [ID_WIDTH-1:0]     r_last_id;
  logic [CW-1:0]           r_count;
  logic [CHANNELS-1:0]     r_req_done;
  logic                    r_req_error;
  logic                    r_req_wdata_valid;
  logic [DATA_WIDTH-1:0]   r_req_wdata;
  logic                    r_ctrl_pending;
  logic                    r_ctrl_irq;
  logic [ID_WIDTH-1:0]     r_ctrl_id;
  logic [DATA_WIDTH-1:0]   r_ctrl_data;

  logic [CHANNELS-1:0]     w_eligible;
  logic                    w_grant_valid;
  logic [ID_WIDTH-1:0]     w_grant_id;
  logic [ID_WIDTH-1:0]     w_cand;
  logic                    w_expired;
  logic [CHANNELS-1:0]     w_done_onehot;
  logic [DATA_WIDTH-1:0]   w_req_arr [CHANNELS];

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_req_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search upward from the channel after the last grant, wrapping modulo CHANNELS.
  always_comb begin
    w_eligible    = req_pending & channel_enable;
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      w_cand = ID_WIDTH'((32'(r_last_id) + i) % CHANNELS);
      if (!w_grant_valid && w_eligible[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  assign w_expired     = (TIMEOUT_CYCLES > 0) && (r_count == CW'(TIMEOUT_CYCLES));
  assign w_done_onehot = CHANNELS'(1) << r_ctrl_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_last_id         <= ID_WIDTH'(CHANNELS - 1);
      r_count           <= '0;
      r_req_done        <= '0;
      r_req_error       <= 1'b0;
      r_req_wdata_valid <= 1'b0;
      r_req_wdata       <= '0;
      r_ctrl_pending    <= 1'b0;
      r_ctrl_irq        <= 1'b0;
      r_ctrl_id         <= '0;
      r_ctrl_data       <= '0;
    end else begin
      r_ctrl_irq  <= 1'b0;
      r_req_done  <= '0;
      r_req_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_ctrl_id      <= w_grant_id;
            r_last_id      <= w_grant_id;
            r_ctrl_data    <= w_req_arr[w_grant_id];
            r_ctrl_pending <= 1'b1;
            r_ctrl_irq     <= 1'b1;
            r_count        <= '0;
            r_state        <= S_OFFERED;
          end
        end
        S_OFFERED, S_SERVICING: begin
          r_count <= r_count + 1'b1;
          // A done coinciding with expiry is a normal completion.
          if (ctrl_done) begin
            r_ctrl_pending    <= 1'b0;
            r_req_wdata       <= ctrl_wdata;
            r_req_wdata_valid <= ctrl_wdata_valid;
            r_req_done        <= w_done_onehot;
            r_state           <= S_COMPLETE;
          end else if (w_expired) begin
            r_ctrl_pending    <= 1'b0;
            r_req_wdata_valid <= 1'b0;
            r_req_error       <= 1'b1;
            r_req_done        <= w_done_onehot;
            r_state           <= S_COMPLETE;
          end else if (r_state == S_OFFERED && ctrl_ack) begin
            r_ctrl_pending <= 1'b0;
            r_state        <= S_SERVICING;
          end
        end
        S_COMPLETE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign req_done        = r_req_done;
  assign req_error       = r_req_error;
  assign req_wdata_valid = r_req_wdata_valid;
  assign req_wdata       = r_req_wdata;
  assign ctrl_pending    = r_ctrl_pending;
  assign ctrl_irq        = r_ctrl_irq;
  assign ctrl_id         = r_ctrl_id;
  assign ctrl_data       = r_ctrl_data;

endmodule
